ret_stack: RTL

Hardware return-address stack for the single-cycle processor. It sits in the next-PC path, between the PC incrementer output and the PC-select multiplexer that feeds the PC register.
- On a call it saves the return address (PC+1) together with the current zero flag.
- On a return it presents the saved address and flag combinationally, so the PC register and zero-flag flip-flop can load them on the same clock edge that pops the entry.

---
 rtl/ret_stack_if.sv | 29 ++
 rtl/ret_stack.sv | 84 ++++++++
 2 files changed

// File: rtl/ret_stack_if.sv
// Call/return port bundle between the next-PC logic and the return-address stack.
// The master drives call/return requests; the slave (the stack) answers with its top entry.
interface ret_stack_if #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
);
    logic                         push;
    logic                         pop;
    logic [WIDTH-1:0]             d;
    logic                         z_in;
    logic                         clr_err;
    logic [WIDTH-1:0]             top;
    logic                         z_top;
    logic                         empty;
    logic                         full;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         ovf;
    logic                         unf;

    modport master (
        output push, pop, d, z_in, clr_err,
        input  top, z_top, empty, full, count, ovf, unf
    );

    modport slave (
        input  push, pop, d, z_in, clr_err,
        output top, z_top, empty, full, count, ovf, unf
    );
endinterface

// File: rtl/ret_stack.sv
// Return-address stack: saves {zero flag, PC+1} on call, presents it combinationally on return.
// Saturating stack pointer with sticky overflow/underflow flags.
module ret_stack #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    ret_stack_if.slave  bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    typedef logic [WIDTH:0] entry_t;

    entry_t          mem [DEPTH];
    entry_t          rd_entry;
    logic [CW-1:0]   sp_q, sp_d;
    logic [AW-1:0]   rd_idx, wr_idx;
    logic            we;
    logic            is_empty, is_full;
    logic            ovf_set, unf_set;
    logic            ovf_q, unf_q;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == FullCnt);
    assign rd_idx   = AW'(sp_q - CW'(1));

    always_comb begin
        sp_d    = sp_q;
        we      = 1'b0;
        wr_idx  = AW'(sp_q);
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case ({bus.push, bus.pop})
            2'b10: begin
                if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    we   = 1'b1;
                    sp_d = sp_q + CW'(1);
                end
            end
            2'b01: begin
                if (is_empty) unf_set = 1'b1;
                else          sp_d    = sp_q - CW'(1);
            end
            2'b11: begin
                // Tail call overwrites the top in place; on an empty stack it is a plain push.
                we = 1'b1;
                if (is_empty) sp_d   = CW'(1);
                else          wr_idx = rd_idx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_set | (ovf_q & ~bus.clr_err);
            unf_q <= unf_set | (unf_q & ~bus.clr_err);
        end
    end

    // Entry storage is not reset; reads are masked while empty.
    always_ff @(posedge clk) begin
        if (we) mem[wr_idx] <= {bus.z_in, bus.d};
    end

    assign rd_entry  = mem[rd_idx];
    assign bus.top   = is_empty ? '0 : rd_entry[WIDTH-1:0];
    assign bus.z_top = is_empty ? 1'b0 : rd_entry[WIDTH];
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.count = sp_q;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
endmodule
